// File: rtl/spike_enc_pkg.sv
// ---------------------------------------------------------------------------
// spike_enc_pkg
// Shared definitions for the spike encoder slice:
//   enc_state_t  - encoder FSM states (IDLE, ENCODE)
//   LFSR_TAPS    - tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   DEFAULT_SEED - power-on value of the stochastic-mode LFSR
// ---------------------------------------------------------------------------
package spike_enc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } enc_state_t;

  // Bits 15, 13, 12 and 10 correspond to the x^16, x^14, x^13 and x^11 terms.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/spike_encoder_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR used as the random source for stochastic rate coding.
// Only instantiated when SPIKE_ENCODER_LFSR_EN is defined.
// Parameters:
//   SEED      - value loaded by load_seed (must be nonzero)
// Ports:
//   clk       - clock, all updates on the rising edge
//   enable    - advance the sequence by one step
//   load_seed - reload SEED (has priority over enable)
//   lfsr      - current register contents
// ---------------------------------------------------------------------------
module lfsr16
  import spike_enc_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        enable,
  input  logic        load_seed,
  output logic [15:0] lfsr
);

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  always_ff @(posedge clk) begin
    if (load_seed) begin
      lfsr <= SEED;
    end else if (enable) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// ---------------------------------------------------------------------------
// spike_encoder
// Rate-codes an 8-bit stimulus intensity into a spike train over a window of
// WINDOW ticks. Deterministic mode uses an 8-bit phase accumulator whose
// carry-out fires a spike; defining SPIKE_ENCODER_LFSR_EN switches to
// stochastic mode, where a spike fires when the low LFSR byte is below the
// intensity.
// Parameters:
//   WINDOW    - ticks per accepted sample (2..255)
//   REFRACT   - cycles of spike suppression after each spike (0..15)
//   LFSR_SEED - LFSR reset value (stochastic mode only)
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset
//   s_valid     - stimulus sample valid
//   s_intensity - stimulus intensity (0 silent, 255 maximum rate)
//   s_ready     - encoder can accept a sample
//   spike_out   - registered spike train
//   busy        - high while encoding a window
//   window_done - pulse coinciding with the last spike slot of a window
//   spike_count - spikes emitted in the current or most recent window
// ---------------------------------------------------------------------------
module spike_encoder
  import spike_enc_pkg::*;
#(
  parameter int          WINDOW    = 16,
  parameter int          REFRACT   = 0,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_intensity,
  output logic       s_ready,
  output logic       spike_out,
  output logic       busy,
  output logic       window_done,
  output logic [7:0] spike_count
);

  localparam logic [7:0] LAST_K    = 8'(WINDOW - 1);
  localparam logic [3:0] REFRACT_L = 4'(REFRACT);

  enc_state_t state_q, state_d;
  logic [7:0] k_q;
  logic [7:0] acc_q;
  logic [7:0] acc_next;
  logic [3:0] rc_q;
  logic [7:0] intensity_q;
  logic       last_tick;
  logic       accept;
  logic       fire;
  logic       tick_fire;

`ifdef SPIKE_ENCODER_LFSR_EN
  logic [15:0] lfsr_q;

  // The sequence advances once per ENCODE cycle and restarts from the seed on
  // reset, so a run after reset reproduces the same spike pattern.
  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .enable    (busy),
    .load_seed (rst),
    .lfsr      (lfsr_q)
  );

  // Stochastic rule: probability of a spike per tick is roughly I/256.
  always_comb begin
    acc_next = acc_q + intensity_q;
    fire     = (lfsr_q[7:0] < intensity_q) && (rc_q == 4'd0);
  end
`else
  logic [8:0] sum;

  // Deterministic rule: the accumulator carry-out is the spike, so I/256 of
  // the ticks fire, evenly spaced.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, intensity_q};
    acc_next = sum[7:0];
    fire     = sum[8] && (rc_q == 4'd0);
  end
`endif

  // Handshake and next-state logic. A new sample can be taken on the last
  // tick of a window, which restarts ENCODE without an idle bubble.
  always_comb begin
    last_tick = (k_q == LAST_K);
    busy      = (state_q == ENCODE);
    s_ready   = (state_q == IDLE) || ((state_q == ENCODE) && last_tick);
    accept    = s_valid && s_ready;
    tick_fire = busy && fire;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ENCODE;
      end
      ENCODE: begin
        if (last_tick) state_d = accept ? ENCODE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath. spike_count follows spike_out: it restarts on the k==0 tick
  // rather than on the accepting edge, so that during a back-to-back restart
  // the final spike of the old window is still counted when window_done is
  // shown. A sample accepted from IDLE clears it immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= 8'd0;
      acc_q       <= 8'd0;
      rc_q        <= 4'd0;
      intensity_q <= 8'd0;
      spike_out   <= 1'b0;
      window_done <= 1'b0;
      spike_count <= 8'd0;
    end else begin
      spike_out   <= tick_fire;
      window_done <= busy && last_tick;

      if (busy) begin
        k_q   <= k_q + 8'd1;
        acc_q <= acc_next;
        if (k_q == 8'd0) begin
          spike_count <= {7'd0, tick_fire};
        end else if (tick_fire && (spike_count != 8'hFF)) begin
          spike_count <= spike_count + 8'd1;
        end
      end

      // A suppressed overflow is simply lost; the accumulator still wraps.
      if (tick_fire) begin
        rc_q <= REFRACT_L;
      end else if (busy && (rc_q != 4'd0)) begin
        rc_q <= rc_q - 4'd1;
      end

      if (accept) begin
        intensity_q <= s_intensity;
        acc_q       <= 8'd0;
        k_q         <= 8'd0;
        rc_q        <= 4'd0;
        if (state_q == IDLE) spike_count <= 8'd0;
      end
    end
  end

endmodule
